// File: rtl/segre_icache_refill_if.sv
// Bundle between the icache, the line-fill engine and memory:
// miss request, single-word memory reads and the line fill pulse.
interface segre_icache_refill_if #(
   parameter int ADDR_SIZE  = 32,
   parameter int WORD_SIZE  = 32,
   parameter int LANE_SIZE  = 128,
   parameter int INDEX_SIZE = 5,
   parameter int BYTE_SIZE  = 4
) ();
   localparam int TAG_SIZE = ADDR_SIZE - INDEX_SIZE - BYTE_SIZE;

   logic                  miss_i;
   logic [ADDR_SIZE-1:0]  miss_addr_i;
   logic                  miss_ready_o;
   logic                  mem_req_o;
   logic [ADDR_SIZE-1:0]  mem_addr_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [WORD_SIZE-1:0]  mem_rdata_i;
   logic                  fill_valid_o;
   logic [INDEX_SIZE-1:0] fill_index_o;
   logic [TAG_SIZE-1:0]   fill_tag_o;
   logic [LANE_SIZE-1:0]  fill_data_o;

   modport slave (
      input  miss_i, miss_addr_i,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output miss_ready_o, mem_req_o, mem_addr_o,
      output fill_valid_o, fill_index_o,
      output fill_tag_o, fill_data_o
   );

   modport master (
      output miss_i, miss_addr_i,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  miss_ready_o, mem_req_o, mem_addr_o,
      input  fill_valid_o, fill_index_o,
      input  fill_tag_o, fill_data_o
   );
endinterface

// File: rtl/segre_icache_refill.sv
// Icache line-fill engine: fetches a missing line word by word
// and writes it into the icache arrays with a one-cycle fill pulse.
module segre_icache_refill #(
   parameter int ADDR_SIZE  = 32,
   parameter int WORD_SIZE  = 32,
   parameter int LANE_SIZE  = 128,
   parameter int INDEX_SIZE = 5,
   parameter int BYTE_SIZE  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   segre_icache_refill_if.slave  bus
);
   localparam int WORDS  = LANE_SIZE / WORD_SIZE;
   localparam int CNT_W  = $clog2(WORDS);
   localparam int OFF_W  = $clog2(WORD_SIZE / 8);
   localparam int LINE_W = ADDR_SIZE - BYTE_SIZE;
   localparam int TAG_W  = LINE_W - INDEX_SIZE;

   typedef enum logic [1:0] {
      S_IDLE, S_REQ, S_WAIT, S_FILL
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [LINE_W-1:0]    line_q, line_d;
   logic [LINE_W-1:0]    fline_q, fline_d;
   logic [LANE_SIZE-1:0] buf_q, buf_d;
   logic [LANE_SIZE-1:0] fdata_q, fdata_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      line_d  = line_q;
      fline_d = fline_q;
      buf_d   = buf_q;
      fdata_d = fdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.miss_i) begin
               line_d  = bus.miss_addr_i[ADDR_SIZE-1:BYTE_SIZE];
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.mem_gnt_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.mem_rvalid_i) begin
               for (int k = 0; k < WORDS; k++) begin
                  if (cnt_q == CNT_W'(k))
                     buf_d[k*WORD_SIZE +: WORD_SIZE] = bus.mem_rdata_i;
               end
               // Output copy keeps fill_* stable while the next miss runs
               if (cnt_q == CNT_W'(WORDS - 1)) begin
                  fdata_d = buf_d;
                  fline_d = line_q;
                  state_d = S_FILL;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_FILL: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         fline_q <= '0;
         buf_q   <= '0;
         fdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         fline_q <= fline_d;
         buf_q   <= buf_d;
         fdata_q <= fdata_d;
      end
   end

   // Word offset is spliced in, so the address never carries out of the line
   assign bus.mem_addr_o   = {line_q, cnt_q, {OFF_W{1'b0}}};
   assign bus.miss_ready_o = (state_q == S_IDLE);
   assign bus.mem_req_o    = (state_q == S_REQ);
   assign bus.fill_valid_o = (state_q == S_FILL);
   assign bus.fill_index_o = fline_q[INDEX_SIZE-1:0];
   assign bus.fill_tag_o   = fline_q[LINE_W-1 -: TAG_W];
   assign bus.fill_data_o  = fdata_q;
endmodule

// File: tb/tb_segre_icache_refill.sv
// Directed bench for the icache line-fill engine with a
// hand-driven memory and hand-computed expected lines.
module tb_segre_icache_refill;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   segre_icache_refill_if bus ();

   segre_icache_refill dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d obs=%h exp=%h",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic reset_chk(input string t);
      chk({t, ".ready"}, 128'(bus.miss_ready_o), 128'd1);
      chk({t, ".req"}, 128'(bus.mem_req_o), 128'd0);
      chk({t, ".fv"}, 128'(bus.fill_valid_o), 128'd0);
      chk({t, ".maddr"}, 128'(bus.mem_addr_o), 128'd0);
      chk({t, ".fidx"}, 128'(bus.fill_index_o), 128'd0);
      chk({t, ".ftag"}, 128'(bus.fill_tag_o), 128'd0);
      chk({t, ".fdata"}, bus.fill_data_o, 128'd0);
   endtask

   task automatic accept(input logic [31:0] a, input bit hold);
      bus.miss_i      = 1'b1;
      bus.miss_addr_i = a;
      chk("acc.ready", 128'(bus.miss_ready_o), 128'd1);
      step();
      cyc = 1;
      if (!hold) bus.miss_i = 1'b0;
      chk("acc.busy", 128'(bus.miss_ready_o), 128'd0);
   endtask

   task automatic serve(input logic [31:0] a,
                        input logic [31:0] d,
                        input int stall);
      bus.mem_gnt_i = 1'b0;
      for (int i = 0; i < stall; i++) begin
         chk("stall.req", 128'(bus.mem_req_o), 128'd1);
         chk("stall.addr", 128'(bus.mem_addr_o), 128'(a));
         step();
      end
      chk("req", 128'(bus.mem_req_o), 128'd1);
      chk("addr", 128'(bus.mem_addr_o), 128'(a));
      chk("req.ready", 128'(bus.miss_ready_o), 128'd0);
      chk("req.fv", 128'(bus.fill_valid_o), 128'd0);
      bus.mem_gnt_i = 1'b1;
      step();
      bus.mem_gnt_i = 1'b0;
      chk("wait.req", 128'(bus.mem_req_o), 128'd0);
      chk("wait.fv", 128'(bus.fill_valid_o), 128'd0);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = d;
      step();
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
   endtask

   task automatic fill_chk(input string t,
                           input logic [127:0] line,
                           input logic [4:0] idx,
                           input logic [22:0] tag);
      chk({t, ".fv"}, 128'(bus.fill_valid_o), 128'd1);
      chk({t, ".data"}, bus.fill_data_o, line);
      chk({t, ".idx"}, 128'(bus.fill_index_o), 128'(idx));
      chk({t, ".tag"}, 128'(bus.fill_tag_o), 128'(tag));
   endtask

   initial begin
      rst              = 1'b1;
      bus.miss_i       = 1'b0;
      bus.miss_addr_i  = '0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
      step();
      step();
      reset_chk("rst");
      rst = 1'b0;

      // 1: zero-wait fill, pulse in cycle 9
      accept(32'h0000_1234, 1'b0);
      serve(32'h1230, 32'h1111_1111, 0);
      serve(32'h1234, 32'h2222_2222, 0);
      serve(32'h1238, 32'h3333_3333, 0);
      serve(32'h123C, 32'h4444_4444, 0);
      chk("t1.cyc9", 128'(bus.fill_valid_o), 128'd1);
      fill_chk("t1", 128'h44444444_33333333_22222222_11111111,
               5'h03, 23'h9);
      step();
      chk("t1.pulse1", 128'(bus.fill_valid_o), 128'd0);
      chk("t1.hold", bus.fill_data_o,
          128'h44444444_33333333_22222222_11111111);
      chk("t1.idle", 128'(bus.miss_ready_o), 128'd1);

      // 2: three gnt stall cycles on word 2 -> pulse in cycle 12
      accept(32'h0000_1234, 1'b0);
      serve(32'h1230, 32'hA0A0_A0A0, 0);
      serve(32'h1234, 32'hA1A1_A1A1, 0);
      serve(32'h1238, 32'hA2A2_A2A2, 3);
      serve(32'h123C, 32'hA3A3_A3A3, 0);
      chk("t2.cyc12", 128'(cyc), 128'd12);
      fill_chk("t2", 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0,
               5'h03, 23'h9);
      step();

      // 3: miss while busy is ignored until after the fill
      accept(32'h0000_1000, 1'b1);
      bus.miss_addr_i = 32'h0000_2000;
      serve(32'h1000, 32'h0000_0B00, 0);
      serve(32'h1004, 32'h0000_0B01, 0);
      serve(32'h1008, 32'h0000_0B02, 0);
      serve(32'h100C, 32'h0000_0B03, 0);
      fill_chk("t3a", 128'h00000B03_00000B02_00000B01_00000B00,
               5'h00, 23'h8);
      step();
      chk("t3.ready", 128'(bus.miss_ready_o), 128'd1);
      step();
      bus.miss_i = 1'b0;
      cyc = 1;
      serve(32'h2000, 32'h0000_0C00, 0);
      serve(32'h2004, 32'h0000_0C01, 0);
      serve(32'h2008, 32'h0000_0C02, 0);
      serve(32'h200C, 32'h0000_0C03, 0);
      fill_chk("t3b", 128'h00000C03_00000C02_00000C01_00000C00,
               5'h00, 23'h10);
      step();

      // 4: reset in WAIT of word 1, then a stray rvalid
      accept(32'h0000_0080, 1'b0);
      serve(32'h0080, 32'hDEAD_0000, 0);
      chk("t4.addr1", 128'(bus.mem_addr_o), 128'h84);
      bus.mem_gnt_i = 1'b1;
      step();
      bus.mem_gnt_i = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      reset_chk("t4");
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'hDEAD_0001;
      step();
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
      reset_chk("t4.stray");
      accept(32'h0000_0040, 1'b0);
      serve(32'h0040, 32'h0000_0400, 0);
      serve(32'h0044, 32'h0000_0401, 0);
      serve(32'h0048, 32'h0000_0402, 0);
      serve(32'h004C, 32'h0000_0403, 0);
      fill_chk("t4", 128'h00000403_00000402_00000401_00000400,
               5'h04, 23'h0);
      step();

      // 5: miss held across two fills
      accept(32'h0000_0100, 1'b1);
      serve(32'h0100, 32'h5000_0000, 0);
      serve(32'h0104, 32'h5000_0001, 0);
      serve(32'h0108, 32'h5000_0002, 0);
      serve(32'h010C, 32'h5000_0003, 0);
      fill_chk("t5a", 128'h50000003_50000002_50000001_50000000,
               5'h10, 23'h0);
      bus.miss_addr_i = 32'h0000_0200;
      step();
      chk("t5.ready", 128'(bus.miss_ready_o), 128'd1);
      step();
      bus.miss_i = 1'b0;
      cyc = 1;
      chk("t5.busy", 128'(bus.miss_ready_o), 128'd0);
      serve(32'h0200, 32'h5100_0000, 0);
      serve(32'h0204, 32'h5100_0001, 0);
      serve(32'h0208, 32'h5100_0002, 0);
      serve(32'h020C, 32'h5100_0003, 0);
      fill_chk("t5b", 128'h51000003_51000002_51000001_51000000,
               5'h00, 23'h1);
      step();

      // 6: top of address space, no wrap
      accept(32'hFFFF_FFFF, 1'b0);
      serve(32'hFFFF_FFF0, 32'h6000_0000, 0);
      serve(32'hFFFF_FFF4, 32'h6000_0001, 0);
      serve(32'hFFFF_FFF8, 32'h6000_0002, 0);
      serve(32'hFFFF_FFFC, 32'h6000_0003, 0);
      fill_chk("t6", 128'h60000003_60000002_60000001_60000000,
               5'h1F, 23'h7F_FFFF);
      step();
      chk("t6.idle", 128'(bus.miss_ready_o), 128'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
